pcpi_modarith_unit: RTL and testbench
=====================================

// Module: pcpi_modarith_unit
// PURPOSE
//  Parametrised PCPI co-processor for modular arithmetic on the custom-0 opcode (ADDMOD, SUBMOD, MULMOD, SETQ).
//  Generalises the fixed-Q custom path of the M-extension controller in three ways:
//   - WIDTH-wide operands.
//   - Runtime-loadable modulus q.
//   - Full 2*WIDTH-bit MULMOD reduction with configurable bits-per-cycle throughput.
//  Sits on the PicoRV32 PCPI bus beside the M-extension co-processor.
// PARAMETERS
//  WIDTH          32     operand/result width; product is 2*WIDTH bits
//  Q_DEFAULT      3329   modulus loaded on reset
//  BITS_PER_CYCLE 1      reduction bits per REDUCE cycle; must be 1, 2 or 4 and must divide 2*WIDTH
//  OPCODE_CUSTOM  7'b0001011  accepted opcode
//  FUNC7_MOD      7'b0000001  accepted func7
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      synchronous, active-high
//  pcpi_valid    in   1      instruction offered by core
//  pcpi_insn     in   32     instruction word
//  pcpi_rs1      in   WIDTH  operand 1
//  pcpi_rs2      in   WIDTH  operand 2
//  pcpi_wr       out  1      write rd; equals pcpi_ready
//  pcpi_rd       out  WIDTH  result; valid only while pcpi_ready, else 0
//  pcpi_wait     out  1      equals pcpi_busy
//  pcpi_busy     out  1      high in EXEC/MUL/REDUCE
//  pcpi_ready    out  1      one-cycle completion pulse
//  q_cur         out  WIDTH  current modulus (debug/observability)
// BEHAVIOUR
//  Interface: one clock clk; reset is synchronous and active-high.
//  Reset: state=IDLE; all outputs 0 except q_cur=Q_DEFAULT. Reset in any state (mid-op) aborts with no ready.
//  Decode: accept only when pcpi_valid, opcode==OPCODE_CUSTOM, func7==FUNC7_MOD and func3 is one of:
//    ADDMOD=000, SUBMOD=001, MULMOD=010, SETQ=011.
//  Any other combination: stay IDLE with no response, so the core's PCPI timeout traps.
//  Operands and func3 are latched on the accepting edge; the cycle valid is sampled in IDLE is cycle N.
//  FSM states: IDLE, EXEC, MUL, REDUCE, DONE.
//  IDLE -> EXEC  for ADDMOD/SUBMOD/SETQ.
//  IDLE -> MUL   for MULMOD.
//  EXEC -> DONE.
//  MUL -> REDUCE; P = rs1*rs2 unsigned, 2*WIDTH bits.
//  REDUCE runs 2*WIDTH/BITS_PER_CYCLE cycles, MSB first. Per bit: R=(R<<1)|P[i]; if R>=q then R-=q. R starts at 0.
//  REDUCE -> DONE after the last step.
//  DONE: pcpi_ready=pcpi_wr=1 and pcpi_rd=result for exactly 1 cycle -> IDLE.
//  No acceptance occurs in the DONE cycle.
//  Latency (ready cycle): ADDMOD/SUBMOD/SETQ N+2; MULMOD N+2+2*WIDTH/BITS_PER_CYCLE (N+66 at defaults).
//  ADDMOD: s=rs1+rs2 (WIDTH+1 bits); result = s>=q ? s-q : s.
//  SUBMOD: result = rs1>=rs2 ? rs1-rs2 : rs1+q-rs2 (WIDTH+1 bit intermediate).
//  ADDMOD/SUBMOD are exact when rs1,rs2<q; otherwise the formulas above are normative, truncated to WIDTH.
//  MULMOD: exact (rs1*rs2) mod q for any operands.
//  SETQ: pcpi_rd = old q. If rs1>=2, q<=rs1 on the DONE edge; otherwise q is unchanged.
//  q is never 0 or 1.
//  Abort: pcpi_valid low in EXEC/MUL/REDUCE -> IDLE next cycle. No ready pulse, q unchanged, datapath regs cleared.
//  q changes only on SETQ commit or reset; an in-flight MULMOD always uses the q latched at acceptance.
// TESTING
//  1 ADDMOD rs1=3000 rs2=1000, q=3329 -> ready at N+2, rd=671; rs1=0 rs2=0 -> rd=0.
//  2 SUBMOD rs1=5 rs2=10 -> rd=3324; rs1=10 rs2=5 -> rd=5; equal operands -> rd=0.
//  3 MULMOD rs1=3328 rs2=3328 -> busy N+1..N+65, ready at N+66, rd=1.
//    MULMOD rs1=rs2=32'hFFFF_FFFF -> rd=(2^32-1)^2 mod 3329.
//  4 SETQ rs1=17 -> rd=3329, q_cur=17; then MULMOD 16*16 -> rd=1.
//    SETQ rs1=1 -> rd=17, q stays 17.
//  5 Unknown func3=111 or func7!=FUNC7_MOD with valid held 20 cycles -> ready/busy stay 0.
//    Drop valid at REDUCE step 10 -> IDLE, no ready; the next ADDMOD completes normally.
//  6 Assert reset during MULMOD REDUCE -> outputs 0, q_cur=3329 the next cycle.
//    Random regression over BITS_PER_CYCLE=1,2,4 and WIDTH=16,32 against a reference model.

Source files
------------

// File: rtl/pcpi_modarith_unit.sv
// pcpi_modarith_unit: PCPI co-processor for modular arithmetic on custom-0.
// Provides ADDMOD, SUBMOD and MULMOD against a runtime-loadable modulus,
// plus SETQ to swap the modulus. MULMOD forms the full double-width product
// and reduces it MSB-first, BITS_PER_CYCLE bits per clock.
module pcpi_modarith_unit #(
    parameter int          WIDTH          = 32,
    parameter int unsigned Q_DEFAULT      = 3329,
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [6:0]  OPCODE_CUSTOM  = 7'b0001011,
    parameter logic [6:0]  FUNC7_MOD      = 7'b0000001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcpi_valid,
    input  logic [31:0]      pcpi_insn,
    input  logic [WIDTH-1:0] pcpi_rs1,
    input  logic [WIDTH-1:0] pcpi_rs2,
    output logic             pcpi_wr,
    output logic [WIDTH-1:0] pcpi_rd,
    output logic             pcpi_wait,
    output logic             pcpi_busy,
    output logic             pcpi_ready,
    output logic [WIDTH-1:0] q_cur
);

    localparam int STEPS = (2 * WIDTH) / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SETQ = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL,
        REDUCE,
        DONE
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     q_reg;
    logic [WIDTH-1:0]     rd_reg;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH-1:0]     op_q;
    logic [1:0]           op_sel;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH:0]       rem;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH:0]       rem_next;
    logic [WIDTH-1:0]     exec_result;
    logic                 decode_ok;
    logic                 accept;
    logic                 in_flight;
    logic                 abort;
    logic                 unused_insn;

    // s = a + b in WIDTH+1 bits, conditionally minus q, truncated to WIDTH.
    function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] q);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q})
            s = s - {1'b0, q};
        return s[WIDTH-1:0];
    endfunction

    // a - b, wrapping through q when b > a; WIDTH+1 bit intermediate.
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] q);
        logic [WIDTH:0] t;
        if (a >= b)
            t = {1'b0, a} - {1'b0, b};
        else
            t = {1'b0, a} + {1'b0, q} - {1'b0, b};
        return t[WIDTH-1:0];
    endfunction

    // Shift BITS_PER_CYCLE product bits into the remainder, MSB first,
    // subtracting q whenever the remainder reaches it. r < q on entry keeps
    // every intermediate below 2q, so WIDTH+1 bits suffice.
    function automatic logic [WIDTH:0] reduce_bits(input logic [WIDTH:0] r_in,
                                                   input logic [BITS_PER_CYCLE-1:0] bits,
                                                   input logic [WIDTH-1:0] q);
        logic [WIDTH:0] r;
        r = r_in;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            r = {r[WIDTH-1:0], bits[i]};
            if (r >= {1'b0, q})
                r = r - {1'b0, q};
        end
        return r;
    endfunction

    assign decode_ok = (pcpi_insn[6:0] == OPCODE_CUSTOM) &&
                       (pcpi_insn[31:25] == FUNC7_MOD) &&
                       !pcpi_insn[14];
    assign accept    = (state == IDLE) && pcpi_valid && decode_ok;
    assign in_flight = (state == EXEC) || (state == MUL) || (state == REDUCE);
    assign abort     = in_flight && !pcpi_valid;

    assign rem_next  = reduce_bits(rem, prod[2*WIDTH-1 -: BITS_PER_CYCLE], op_q);

    // Single-cycle result for the non-multiply operations.
    always_comb begin
        exec_result = '0;
        case (op_sel)
            OP_ADD:  exec_result = add_mod(op_a, op_b, op_q);
            OP_SUB:  exec_result = sub_mod(op_a, op_b, op_q);
            OP_SETQ: exec_result = op_q;
            default: exec_result = '0;
        endcase
    end

    // Control FSM, result register and modulus register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            q_reg  <= WIDTH'(Q_DEFAULT);
            rd_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_reg <= '0;
                    if (accept)
                        state <= pcpi_insn[13] && !pcpi_insn[12] ? MUL : EXEC;
                end
                EXEC: begin
                    if (!pcpi_valid) begin
                        state <= IDLE;
                    end else begin
                        state  <= DONE;
                        rd_reg <= exec_result;
                    end
                end
                MUL: begin
                    state <= pcpi_valid ? REDUCE : IDLE;
                end
                REDUCE: begin
                    if (!pcpi_valid) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        rd_reg <= rem_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    rd_reg <= '0;
                    if (op_sel == OP_SETQ && op_a >= WIDTH'(2))
                        q_reg <= op_a;
                end
                default: begin
                    state  <= IDLE;
                    rd_reg <= '0;
                end
            endcase
        end
    end

    // Operand latch, product and serial reduction datapath.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a   <= pcpi_rs1;
            op_b   <= pcpi_rs2;
            op_q   <= q_reg;
            op_sel <= pcpi_insn[13:12];
            rem    <= '0;
            cnt    <= CNT_W'(STEPS);
        end else if (abort) begin
            op_a   <= '0;
            op_b   <= '0;
            op_q   <= '0;
            op_sel <= '0;
            prod   <= '0;
            rem    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            prod <= {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
            rem  <= '0;
            cnt  <= CNT_W'(STEPS);
        end else if (state == REDUCE) begin
            rem  <= rem_next;
            prod <= prod << BITS_PER_CYCLE;
            cnt  <= cnt - CNT_W'(1);
        end
    end

    assign pcpi_ready  = (state == DONE);
    assign pcpi_wr     = pcpi_ready;
    assign pcpi_busy   = in_flight;
    assign pcpi_wait   = pcpi_busy;
    assign pcpi_rd     = rd_reg;
    assign q_cur       = q_reg;
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

endmodule

// File: tb/tb_pcpi_modarith_unit.sv
// Directed bench for pcpi_modarith_unit: a 32-bit, 1-bit-per-cycle instance
// and a 16-bit, 4-bits-per-cycle instance, checked against hand values and a
// small reference model.
module tb_pcpi_modarith_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] insn;
    logic [31:0] rs1, rs2;
    logic        wr, wait_o, busy, ready;
    logic [31:0] rd_o, q_cur;

    logic        valid2;
    logic [31:0] insn2;
    logic [15:0] a2, b2;
    logic        wr2, wait2, busy2, ready2;
    logic [15:0] rd2, q_cur2;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    int          lat, bc;

    localparam logic [6:0] F7 = 7'b0000001;

    always #5 clk = ~clk;

    pcpi_modarith_unit #(.WIDTH(32), .Q_DEFAULT(3329), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .pcpi_valid(valid), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr), .pcpi_rd(rd_o),
        .pcpi_wait(wait_o), .pcpi_busy(busy), .pcpi_ready(ready), .q_cur(q_cur)
    );

    pcpi_modarith_unit #(.WIDTH(16), .Q_DEFAULT(3329), .BITS_PER_CYCLE(4)) dut2 (
        .clk(clk), .reset(reset), .pcpi_valid(valid2), .pcpi_insn(insn2),
        .pcpi_rs1(a2), .pcpi_rs2(b2), .pcpi_wr(wr2), .pcpi_rd(rd2),
        .pcpi_wait(wait2), .pcpi_busy(busy2), .pcpi_ready(ready2), .q_cur(q_cur2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 10'd0, f3, 5'd0, 7'b0001011};
    endfunction

    function automatic logic [31:0] m_add(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q);
        logic [63:0] s;
        s = a + b;
        if (s >= q) s = s - q;
        return s[31:0];
    endfunction

    function automatic logic [31:0] m_sub(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q);
        logic [63:0] s;
        s = (a >= b) ? a - b : a + q - b;
        return s[31:0];
    endfunction

    function automatic logic [31:0] m_mul(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q);
        logic [63:0] p;
        p = (a * b) % q;
        return p[31:0];
    endfunction

    // Issue one instruction on the 32-bit instance, wait for ready (bounded).
    task automatic run_op(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int l, output int busy_cnt);
        @(posedge clk); #1;
        insn = mk_insn(f7, f3); rs1 = a; rs2 = b; valid = 1'b1;
        l = 0; busy_cnt = 0; r = '0;
        while (l < 200) begin
            @(posedge clk); #1;
            l++;
            if (ready) begin
                r = rd_o;
                break;
            end
            if (busy && wait_o) busy_cnt++;
        end
        valid = 1'b0;
    endtask

    // Same for the 16-bit instance.
    task automatic run_op2(input logic [2:0] f3, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output int l);
        @(posedge clk); #1;
        insn2 = mk_insn(F7, f3); a2 = a; b2 = b; valid2 = 1'b1;
        l = 0; r = '0;
        while (l < 200) begin
            @(posedge clk); #1;
            l++;
            if (ready2) begin
                r = rd2;
                check("dut2 wr/wait at ready", {62'd0, wr2, wait2}, 64'd2);
                break;
            end
        end
        valid2 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, exp;
        logic [15:0] r16;
        int op, seen;

        reset = 1'b1; valid = 1'b0; insn = '0; rs1 = '0; rs2 = '0;
        valid2 = 1'b0; insn2 = '0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready/busy/wr/wait", {60'd0, ready, busy, wr, wait_o}, 64'd0);
        check("reset rd", rd_o, 0);
        check("reset q_cur", q_cur, 3329);
        check("reset q_cur dut2", q_cur2, 3329);
        reset = 1'b0;

        // ADDMOD
        run_op(F7, 3'b000, 3000, 1000, rd, lat, bc);
        check("addmod 3000+1000 rd", rd, 671);
        check("addmod latency", lat, 2);
        check("addmod busy cycles", bc, 1);
        check("addmod wr at ready", wr, 1);
        run_op(F7, 3'b000, 0, 0, rd, lat, bc);
        check("addmod 0+0 rd", rd, 0);
        @(posedge clk); #1;
        check("idle after done ready", ready, 0);
        check("idle after done rd", rd_o, 0);

        // SUBMOD
        run_op(F7, 3'b001, 5, 10, rd, lat, bc);
        check("submod 5-10 rd", rd, 3324);
        run_op(F7, 3'b001, 10, 5, rd, lat, bc);
        check("submod 10-5 rd", rd, 5);
        run_op(F7, 3'b001, 7, 7, rd, lat, bc);
        check("submod 7-7 rd", rd, 0);

        // MULMOD
        run_op(F7, 3'b010, 3328, 3328, rd, lat, bc);
        check("mulmod 3328^2 rd", rd, 1);
        check("mulmod latency", lat, 66);
        check("mulmod busy cycles", bc, 65);
        run_op(F7, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rd, lat, bc);
        check("mulmod ffffffff^2 rd", rd, 283);

        // SETQ
        run_op(F7, 3'b011, 17, 0, rd, lat, bc);
        check("setq 17 rd old q", rd, 3329);
        check("setq latency", lat, 2);
        @(posedge clk); #1;
        check("setq q_cur", q_cur, 17);
        run_op(F7, 3'b010, 16, 16, rd, lat, bc);
        check("mulmod 16*16 mod 17", rd, 1);
        run_op(F7, 3'b000, 10, 9, rd, lat, bc);
        check("addmod 10+9 mod 17", rd, 2);
        run_op(F7, 3'b011, 1, 0, rd, lat, bc);
        check("setq 1 rd", rd, 17);
        @(posedge clk); #1;
        check("setq 1 keeps q", q_cur, 17);
        run_op(F7, 3'b011, 3329, 0, rd, lat, bc);
        check("setq 3329 rd", rd, 17);
        @(posedge clk); #1;
        check("setq 3329 q_cur", q_cur, 3329);

        // Undecodable instructions are ignored
        @(posedge clk); #1;
        insn = mk_insn(F7, 3'b111); rs1 = 1; rs2 = 2; valid = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || ready) seen++;
        end
        check("func3=111 ignored", seen, 0);
        insn = mk_insn(7'b0000000, 3'b000);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || ready) seen++;
        end
        check("func7 mismatch ignored", seen, 0);
        valid = 1'b0;

        // Abort mid-REDUCE by dropping valid at step 10
        @(posedge clk); #1;
        insn = mk_insn(F7, 3'b010); rs1 = 3328; rs2 = 3328; valid = 1'b1;
        repeat (11) begin
            @(posedge clk); #1;
        end
        check("busy at reduce step 10", busy, 1);
        valid = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy || ready) seen++;
        end
        check("abort no ready/busy", seen, 0);
        check("abort q unchanged", q_cur, 3329);
        run_op(F7, 3'b000, 3000, 1000, rd, lat, bc);
        check("addmod after abort rd", rd, 671);
        check("addmod after abort latency", lat, 2);

        // Reset during REDUCE restores the default modulus
        run_op(F7, 3'b011, 17, 0, rd, lat, bc);
        @(posedge clk); #1;
        check("pre-reset q_cur", q_cur, 17);
        @(posedge clk); #1;
        insn = mk_insn(F7, 3'b010); rs1 = 3328; rs2 = 3328; valid = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset mid-op busy/ready", {62'd0, busy, ready}, 0);
        check("reset mid-op rd", rd_o, 0);
        check("reset mid-op q_cur", q_cur, 3329);
        reset = 1'b0; valid = 1'b0;

        // Random regression on the 32-bit, 1-bit-per-cycle instance
        for (int i = 0; i < 12; i++) begin
            op = $urandom_range(0, 2);
            if (op == 2) begin
                ra = $urandom; rb = $urandom;
                exp = m_mul(ra, rb, 3329);
            end else begin
                ra = $urandom_range(0, 3328); rb = $urandom_range(0, 3328);
                exp = (op == 0) ? m_add(ra, rb, 3329) : m_sub(ra, rb, 3329);
            end
            run_op(F7, 3'(op), ra, rb, rd, lat, bc);
            check("random rd", rd, exp);
            check("random latency", lat, (op == 2) ? 66 : 2);
        end

        // 16-bit, 4-bits-per-cycle instance
        run_op2(3'b010, 16'hFFFF, 16'hFFFF, r16, lat);
        check("dut2 mulmod ffff^2", r16, m_mul(64'hFFFF, 64'hFFFF, 3329));
        check("dut2 mulmod latency", lat, 10);
        run_op2(3'b000, 3000, 1000, r16, lat);
        check("dut2 addmod", r16, 671);
        for (int i = 0; i < 8; i++) begin
            ra = 32'($urandom_range(0, 65535)); rb = 32'($urandom_range(0, 65535));
            run_op2(3'b010, ra[15:0], rb[15:0], r16, lat);
            check("dut2 random mulmod", r16, m_mul(ra, rb, 3329));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
